nrzi_frame_ctrl: RTL
====================

// Module: nrzi_frame_ctrl
// PURPOSE
//  Frame sequencer for the mealy_nrzi encoder. Accepts parallel words over a
//  valid/ready handshake, clears the encoder for a fixed gap, then serializes
//  the word MSB-first onto the encoder input x, one bit per clock.
//  Sits between the word source and mealy_nrzi; reports frame completion and a frame count.
// PARAMETERS
//  WIDTH  16  bits per frame (word width); >= 2
//  GAP    2   cycles enc_clr held high before the first bit of each frame; >= 1
//  CNT_W  8   width of frame_cnt
// PORTS
//  clock       in   1        system clock, rising-edge
//  reset       in   1        asynchronous, active-low reset
//  word_in     in   WIDTH    frame word, sampled on accept
//  word_valid  in   1        source has a word on word_in
//  word_ready  out  1        controller can accept a word (high only in IDLE)
//  abort       in   1        synchronous frame abort
//  x_out       out  1        serial bit to encoder input x
//  enc_clr     out  1        clear to encoder state (high during CLEAR)
//  busy        out  1        high in CLEAR, SHIFT, DONE
//  done        out  1        one-cycle pulse after last bit of a completed frame
//  frame_cnt   out  CNT_W    completed-frame count, wraps to 0
// BEHAVIOUR
//  - reset low (async): state=IDLE, shreg=0, bit_cnt=0, gap_cnt=0, x_out=0,
//    enc_clr=0, busy=0, done=0, frame_cnt=0. word_ready=1 (decoded from IDLE).
//  - All outputs except word_ready are registered. word_ready = (state==IDLE).
//  - States: IDLE, CLEAR, SHIFT, DONE.
//  - IDLE: x_out=0, enc_clr=0. Accept on the edge with word_valid&&word_ready:
//    shreg<=word_in, gap_cnt<=0, bit_cnt<=0, go CLEAR. abort is ignored in IDLE.
//  - CLEAR: enc_clr=1, x_out=0 for exactly GAP cycles, then SHIFT.
//  - SHIFT: x_out = shreg[WIDTH-1]; shreg shifts left one per cycle.
//    bit_cnt counts 0..WIDTH-1. Exactly WIDTH cycles, then DONE.
//  - DONE: one cycle; done=1, x_out=0, frame_cnt<=frame_cnt+1 (mod 2^CNT_W). Then IDLE.
//  - Timing: accept at edge k -> enc_clr high cycles k+1..k+GAP.
//    Bit i (0 = MSB) on x_out in cycle k+GAP+1+i.
//    done in cycle k+GAP+WIDTH+1. word_ready high again in cycle k+GAP+WIDTH+2.
//  - Back-to-back: with word_valid held, the next word is accepted at the end of the first IDLE cycle.
//    Inter-frame spacing: DONE + 1 IDLE + GAP CLEAR cycles.
//  - word_valid outside IDLE: no effect; word is not consumed; source must hold it.
//  - abort high in CLEAR or SHIFT: next edge -> IDLE.
//    x_out=0, enc_clr=0, no done, frame_cnt unchanged, shreg discarded.
//  - abort in DONE: ignored; the frame counts as completed.
//  - abort and word_valid together in IDLE: word accepted.
//  - reset asserted mid-frame: all state and outputs return to reset values immediately, without waiting for clock.
//    The frame is lost; frame_cnt=0.
// TESTING  (WIDTH=16, GAP=2, CNT_W=8)
//  - Reset low, no clock -> word_ready=1, x_out=0, enc_clr=0, busy=0, done=0, frame_cnt=0.
//  - 16'hF161 accepted at edge k -> enc_clr=1 in k+1,k+2.
//    x_out=1111_0001_0110_0001 in k+3..k+18. done=1 in k+19. frame_cnt=1.
//  - 16'hCF0C then 16'h8C00 with word_valid held -> second accepted at end of first IDLE cycle after done.
//    Serial streams 1100_1111_0000_1100 and 1000_1100_0000_0000. frame_cnt=2.
//  - word_valid toggled with 16'hAAAA during SHIFT of 16'hF161 -> no accept.
//    x_out stream unchanged. word_ready=0 until IDLE.
//  - abort during bit 5 of 16'h8C00 -> IDLE next edge, x_out=0, no done, frame_cnt unchanged.
//    The next word still gets a full GAP clear.
//  - Reset pulsed mid-SHIFT -> outputs reset asynchronously.
//    256 completed frames from reset -> frame_cnt wraps 255->0.

Source files
------------

// File: rtl/nrzi_frame_ctrl.sv
// Frame sequencer for the mealy_nrzi encoder: accepts a word, clears the
// encoder for GAP cycles, then shifts the word out MSB-first on x_out.
module nrzi_frame_ctrl #(
    parameter int WIDTH = 16,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             abort,
    output logic             x_out,
    output logic             enc_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    assign word_ready = (state == IDLE);

    // Outputs are registered alongside the state, so every transition sets
    // the values that belong to the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            x_out     <= 1'b0;
            enc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    x_out   <= 1'b0;
                    enc_clr <= 1'b0;
                    done    <= 1'b0;
                    if (word_valid) begin
                        shreg   <= word_in;
                        gap_cnt <= '0;
                        bit_cnt <= '0;
                        enc_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        x_out   <= 1'b0;
                        enc_clr <= 1'b0;
                        busy    <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= SHIFT;
                        enc_clr <= 1'b0;
                        x_out   <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // bit_cnt tracks the bit currently presented on x_out
                    if (abort) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        x_out   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (bit_cnt == BIT_LAST) begin
                        state   <= DONE;
                        x_out   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        x_out   <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    frame_cnt <= frame_cnt + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
